// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem read, decode handshake.
// Optional delivered-instruction counter enabled by define PC_FETCH_CNT_EN.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_instr_ready,
   output logic        o_misaligned
`ifdef PC_FETCH_CNT_EN
   ,
   output logic [31:0] o_fetch_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        kill_q, kill_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        mis_q, mis_d;

   logic        redir_ok;
   logic        redir_bad;
   logic        gnt_ok;
   logic        rv_ok;
   logic        hs;
   logic [31:0] pc_inc;

   assign redir_ok  = i_redirect & (i_redirect_pc[1:0] == 2'b00);
   assign redir_bad = i_redirect & (i_redirect_pc[1:0] != 2'b00);
   assign gnt_ok    = (state_q == S_REQ) & i_imem_gnt;
   assign rv_ok     = (state_q == S_WAIT) & i_imem_rvalid;
   assign hs        = (state_q == S_HOLD) & i_instr_ready;
   assign pc_inc    = pc_q + 32'd4;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; a granted request always runs to WAIT
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!i_stall) state_d = S_REQ;
         end
         S_REQ: begin
            if (i_imem_gnt) begin
               state_d = S_WAIT;
            end else if (redir_ok && i_stall) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               state_d = (kill_q || redir_ok) ? S_IDLE : S_HOLD;
            end
         end
         S_HOLD: begin
            if (redir_ok) begin
               state_d = S_IDLE;
            end else if (i_instr_ready) begin
               state_d = i_stall ? S_IDLE : S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: PC, captured address, kill flag, fetched word
   always_comb begin
      pc_d    = pc_q;
      addr_d  = addr_q;
      kill_d  = kill_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      mis_d   = redir_bad;
      if (redir_ok) begin
         pc_d = i_redirect_pc;
      end else if (gnt_ok) begin
         pc_d = pc_inc;
      end
      if (gnt_ok) begin
         addr_d = pc_q;
         kill_d = redir_ok;
      end
      if (state_q == S_WAIT) begin
         if (i_imem_rvalid) begin
            kill_d = 1'b0;
         end else if (redir_ok) begin
            kill_d = 1'b1;
         end
      end
      if (rv_ok && !kill_q && !redir_ok) begin
         instr_d = i_imem_rdata;
         ipc_d   = addr_q;
      end
   end

   // Datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q    <= RESET_PC;
         addr_q  <= 32'h0;
         kill_q  <= 1'b0;
         instr_q <= 32'h0;
         ipc_q   <= 32'h0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         kill_q  <= kill_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         mis_q   <= mis_d;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      o_imem_req    = (state_q == S_REQ);
      o_instr_valid = (state_q == S_HOLD);
   end

   assign o_imem_addr  = pc_q;
   assign o_instr      = instr_q;
   assign o_instr_pc   = ipc_q;
   assign o_misaligned = mis_q;

`ifdef PC_FETCH_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   assign cnt_d = hs ? cnt_q + 32'd1 : cnt_q;

   // Delivered-instruction counter, wraps naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= 32'h0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_fetch_cnt = cnt_q;
`else
   logic unused_hs;
   assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetches, redirects, kill, wrap, reset.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, redirect, ready;
   logic [31:0] redirect_pc;
   logic        req, gnt, rvalid, ivalid, mis;
   logic [31:0] addr, rdata, instr, ipc;
   logic        gnt_en, ovr_en;
   logic [31:0] ovr;
   int          lat;

   logic        stall2, req2, gnt2, ivalid2, mis2;
   logic        rv2 = 1'b0;
   logic [31:0] addr2, instr2, ipc2;
   logic [31:0] rd2 = 32'h0;
   logic        redir0 = 1'b0;
   logic        ready2 = 1'b1;
   logic [31:0] rpc0 = 32'h0;
`ifdef PC_FETCH_CNT_EN
   logic [31:0] fcnt, fcnt2;
`endif

   pc_fetch_unit u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
      .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
      .o_instr_valid(ivalid), .o_instr(instr), .o_instr_pc(ipc),
      .i_instr_ready(ready), .o_misaligned(mis)
`ifdef PC_FETCH_CNT_EN
      , .o_fetch_cnt(fcnt)
`endif
   );

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall2),
      .i_redirect(redir0), .i_redirect_pc(rpc0),
      .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_gnt(gnt2),
      .i_imem_rvalid(rv2), .i_imem_rdata(rd2),
      .o_instr_valid(ivalid2), .o_instr(instr2), .o_instr_pc(ipc2),
      .i_instr_ready(ready2), .o_misaligned(mis2)
`ifdef PC_FETCH_CNT_EN
      , .o_fetch_cnt(fcnt2)
`endif
   );

   // Memory model: returns the address as data after lat extra cycles
   logic        pend = 1'b0;
   logic [31:0] paddr = 32'h0;
   int          mcnt = 0;
   assign gnt    = req & gnt_en;
   assign rvalid = pend && (mcnt == 0);
   assign rdata  = ovr_en ? ovr : paddr;
   always @(posedge clk) begin
      if (pend) begin
         if (mcnt == 0) pend <= 1'b0;
         else mcnt <= mcnt - 1;
      end
      if (req && gnt) begin
         pend  <= 1'b1;
         paddr <= addr;
         mcnt  <= lat;
      end
   end

   assign gnt2 = req2;
   always @(posedge clk) begin
      rv2 <= req2 & gnt2;
      rd2 <= addr2;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_err = 0;
   int          hs_cnt = 0;
   int          hs2 = 0;
   int          last_hs = 0;
   int          rel_cyc = 0;
   int          nhs = 0;
   bit          rate_chk = 1'b0;
   logic [31:0] q[$];
   logic [31:0] q2[$];
   logic [31:0] e_m;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: pop the expected word on every delivered instruction
   always @(negedge clk) begin
      if (rst_n && ivalid && ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexp_hs: got pc %h instr %h want none", ipc, instr);
         end else begin
            e_m = q.pop_front();
            check("hs_pc", ipc, e_m);
            check("hs_instr", instr, e_m);
         end
         if (rate_chk)
            check("hs_gap", cyc - (hs_cnt == 0 ? rel_cyc : last_hs), 3);
         last_hs = cyc;
         hs_cnt++;
      end
      if (rst_n && ivalid2 && ready2) begin
         if (q2.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexp_hs2: got pc %h want none", ipc2);
         end else begin
            e_m = q2.pop_front();
            check("wrap_pc", ipc2, e_m);
            check("wrap_instr", instr2, e_m);
         end
         hs2++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int n);
      int g = 0;
      while (hs_cnt < n && g < 60) begin
         tick();
         g++;
      end
      check("wait_hs", hs_cnt, n);
   endtask

   task automatic wait_req();
      int g = 0;
      while (!req && g < 60) begin
         tick();
         g++;
      end
      check("wait_req", {31'h0, req}, 1);
   endtask

   task automatic wait_valid();
      int g = 0;
      while (!ivalid && g < 60) begin
         tick();
         g++;
      end
      check("wait_valid", {31'h0, ivalid}, 1);
   endtask

   task automatic fetch_one(input logic [31:0] a);
      q.push_back(a);
      stall = 1'b0;
      wait_req();
      check("req_addr", addr, a);
      stall = 1'b1;
      nhs++;
      wait_hs(nhs);
   endtask

   initial begin
      int g;
      rst_n = 1'b0; stall = 1'b1; stall2 = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
      gnt_en = 1'b1; lat = 0; ovr_en = 1'b0; ovr = 32'h0;
      repeat (3) tick();
      check("rst_req", {31'h0, req}, 0);
      check("rst_addr", addr, 32'h0);
      check("rst_valid", {31'h0, ivalid}, 0);
      check("rst_instr", instr, 32'h0);
      check("rst_ipc", ipc, 32'h0);
      check("rst_mis", {31'h0, mis}, 0);
      check("rst_addr2", addr2, 32'hFFFF_FFF8);
      check("rst_mis2", {31'h0, mis2}, 0);
`ifdef PC_FETCH_CNT_EN
      check("rst_cnt", fcnt, 32'h0);
      check("rst_cnt2", fcnt2, 32'h0);
`endif

      // Sequential fetch, zero-wait memory, 1 per 3 cycles
      q.push_back(32'h0); q.push_back(32'h4);
      q.push_back(32'h8); q.push_back(32'hC);
      stall = 1'b0;
      rate_chk = 1'b1;
      rel_cyc = cyc;
      rst_n = 1'b1;
      wait_hs(3);
      stall = 1'b1;
      wait_hs(4);
      nhs = 4;
      rate_chk = 1'b0;

      // Redirect while waiting: late DEAD data must be dropped
      lat = 2; ovr_en = 1'b1; ovr = 32'hDEAD;
      stall = 1'b0;
      wait_req();
      check("kill_req_addr", addr, 32'h10);
      stall = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      repeat (5) tick();
      check("kill_nohs", hs_cnt, nhs);
      check("kill_idle", {31'h0, req}, 0);
      check("kill_newpc", addr, 32'h100);
      lat = 0; ovr_en = 1'b0;
      fetch_one(32'h100);

      // Misaligned redirect ignored, one-cycle flag
      redirect = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
      check("mis_pulse", {31'h0, mis}, 1);
      tick();
      check("mis_clear", {31'h0, mis}, 0);
      check("mis_pc", addr, 32'h104);
      fetch_one(32'h104);

      // Grant withheld with stall toggling; HOLD with ready low
      gnt_en = 1'b0;
      q.push_back(32'h108);
      stall = 1'b0;
      wait_req();
      for (int i = 0; i < 5; i++) begin
         check("gw_req", {31'h0, req}, 1);
         check("gw_addr", addr, 32'h108);
         stall = ~stall;
         tick();
      end
      stall = 1'b1; ready = 1'b0; gnt_en = 1'b1;
      wait_valid();
      for (int i = 0; i < 4; i++) begin
         check("hold_valid", {31'h0, ivalid}, 1);
         check("hold_instr", instr, 32'h108);
         check("hold_ipc", ipc, 32'h108);
         tick();
      end
      ready = 1'b1;
      nhs++;
      wait_hs(nhs);

      // Redirect in REQ with same-cycle grant kills that request
      stall = 1'b0;
      wait_req();
      check("rk_addr", addr, 32'h10C);
      redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
      tick();
      redirect = 1'b0;
      repeat (4) tick();
      check("rk_nohs", hs_cnt, nhs);
      check("rk_pc", addr, 32'h200);
      fetch_one(32'h200);
      fetch_one(32'h204);

      // Redirect in HOLD with ready: handshake still completes
      q.push_back(32'h208);
      stall = 1'b0;
      wait_req();
      check("hr_addr", addr, 32'h208);
      stall = 1'b1;
      wait_valid();
      redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      nhs++;
      check("hr_hs", hs_cnt, nhs);
      check("hr_valid", {31'h0, ivalid}, 0);
      check("hr_pc", addr, 32'h300);
`ifdef PC_FETCH_CNT_EN
      check("cnt_10", fcnt, 32'd10);
`endif

      // PC wrap on the second instance
      q2.push_back(32'hFFFF_FFF8);
      q2.push_back(32'hFFFF_FFFC);
      q2.push_back(32'h0);
      stall2 = 1'b0;
      g = 0;
      while (hs2 < 2 && g < 60) begin
         tick();
         g++;
      end
      stall2 = 1'b1;
      g = 0;
      while (hs2 < 3 && g < 60) begin
         tick();
         g++;
      end
      check("wrap_hs", hs2, 3);
      check("wrap_next", addr2, 32'h4);

      // Reset in the middle of WAIT; late rvalid ignored
      lat = 3;
      stall = 1'b0;
      wait_req();
      check("rw_addr", addr, 32'h300);
      stall = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      check("rw_req", {31'h0, req}, 0);
      check("rw_addr0", addr, 32'h0);
      check("rw_valid", {31'h0, ivalid}, 0);
      check("rw_instr", instr, 32'h0);
      check("rw_ipc", ipc, 32'h0);
      check("rw_mis", {31'h0, mis}, 0);
`ifdef PC_FETCH_CNT_EN
      check("rw_cnt", fcnt, 32'h0);
`endif
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("rw_nohs", hs_cnt, nhs);
      check("rw_idle_valid", {31'h0, ivalid}, 0);
      check("rw_idle_req", {31'h0, req}, 0);

      check("q_empty", q.size(), 0);
      check("q2_empty", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
